// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer: turns game event pulses (flip, match, win) into short
// ASCII messages handed one byte at a time to a UART transmitter.
// Events are captured into per-source pending flags. A fixed-priority arbiter
// (win > match > flip) moves them into a 4-entry FIFO, and a three-state FSM
// streams each FIFO entry out as a complete message.
// Optional feature: define UART_SEQ_DROP_CNT_EN to add the drop_count port and
// a saturating counter of events lost to overwrite while still pending.
module uart_msg_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] card_pos,
   input  logic       card_flipped,
   input  logic       card_matched,
   input  logic       game_won,
   input  logic [7:0] move_count,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       busy
`ifdef UART_SEQ_DROP_CNT_EN
   ,
   output logic [7:0] drop_count
`endif
);

   localparam logic [1:0] T_FLIP  = 2'd0;
   localparam logic [1:0] T_MATCH = 2'd1;
   localparam logic [1:0] T_WIN   = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

   // Uppercase ASCII hex digit for a nibble.
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Byte idx of the message built from one FIFO entry.
   function automatic logic [7:0] msg_byte(input logic [1:0] typ,
                                           input logic [7:0] pay,
                                           input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      if (typ == T_WIN) begin
         case (idx)
            3'd0:    b = 8'h57;
            3'd1:    b = hex_ascii(pay[7:4]);
            3'd2:    b = hex_ascii(pay[3:0]);
            3'd3:    b = 8'h0D;
            default: b = 8'h0A;
         endcase
      end else begin
         case (idx)
            3'd0:    b = (typ == T_MATCH) ? 8'h4D : 8'h46;
            3'd1:    b = hex_ascii(pay[3:0]);
            3'd2:    b = 8'h0D;
            default: b = 8'h0A;
         endcase
      end
      msg_byte = b;
   endfunction

   // pending capture
   logic       r_pend_f, r_pend_m, r_pend_w;
   logic [3:0] r_pos_f, r_pos_m;
   logic [7:0] r_mv_w;

   // message FIFO: {type[1:0], payload[7:0]}
   logic [9:0] r_fifo [0:3];
   logic [1:0] r_wr_ptr, r_rd_ptr;
   logic [2:0] r_count;

   // sender
   state_t     r_state, w_state_nxt;
   logic [1:0] r_msg_type;
   logic [7:0] r_msg_pay;
   logic [2:0] r_idx;
   logic [7:0] r_tx_data;
   logic       r_busy;

   logic       w_pop, w_adv, w_last, w_can_push, w_push;
   logic       w_gnt_f, w_gnt_m, w_gnt_w;
   logic [9:0] w_push_data, w_head;

   assign w_head = r_fifo[r_rd_ptr];
   assign w_last = (r_msg_type == T_WIN) ? (r_idx == 3'd4) : (r_idx == 3'd3);

   // A full FIFO still accepts a push when the FSM pops in the same cycle.
   assign w_can_push = (r_count != 3'd4) | w_pop;
   assign w_gnt_w    = w_can_push & r_pend_w;
   assign w_gnt_m    = w_can_push & r_pend_m & ~r_pend_w;
   assign w_gnt_f    = w_can_push & r_pend_f & ~r_pend_w & ~r_pend_m;
   assign w_push     = w_gnt_w | w_gnt_m | w_gnt_f;

   // arbiter: select the winning pending source's FIFO entry
   always_comb begin
      w_push_data = {T_FLIP, 4'h0, r_pos_f};
      if (w_gnt_w)      w_push_data = {T_WIN, r_mv_w};
      else if (w_gnt_m) w_push_data = {T_MATCH, 4'h0, r_pos_m};
   end

   // FSM next-state and outputs; tx_done only matters in WAIT
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_adv       = 1'b0;
      tx_start    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != 3'd0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            tx_start    = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               if (w_last) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_adv       = 1'b1;
                  w_state_nxt = S_SEND;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // pending flags: set on pulse, cleared on grant; a pulse beats a grant
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_f <= 1'b0;
         r_pend_m <= 1'b0;
         r_pend_w <= 1'b0;
         r_pos_f  <= 4'h0;
         r_pos_m  <= 4'h0;
         r_mv_w   <= 8'h00;
      end else begin
         r_pend_f <= card_flipped | (r_pend_f & ~w_gnt_f);
         r_pend_m <= card_matched | (r_pend_m & ~w_gnt_m);
         r_pend_w <= game_won     | (r_pend_w & ~w_gnt_w);
         if (card_flipped) r_pos_f <= card_pos;
         if (card_matched) r_pos_m <= card_pos;
         if (game_won)     r_mv_w  <= move_count;
      end
   end

   // FIFO storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_data;
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // message register, byte index and the held tx_data byte
   always_ff @(posedge clk) begin
      if (reset) begin
         r_msg_type <= T_FLIP;
         r_msg_pay  <= 8'h00;
         r_idx      <= 3'd0;
         r_tx_data  <= 8'h00;
      end else if (w_pop) begin
         r_msg_type <= w_head[9:8];
         r_msg_pay  <= w_head[7:0];
         r_idx      <= 3'd0;
         r_tx_data  <= msg_byte(w_head[9:8], w_head[7:0], 3'd0);
      end else if (w_adv) begin
         r_idx      <= r_idx + 3'd1;
         r_tx_data  <= msg_byte(r_msg_type, r_msg_pay, r_idx + 3'd1);
      end
   end

   // registered busy
   always_ff @(posedge clk) begin
      if (reset) r_busy <= 1'b0;
      else       r_busy <= r_pend_f | r_pend_m | r_pend_w | (r_count != 3'd0) |
                           (r_state != S_IDLE);
   end

   assign tx_data = r_tx_data;
   assign busy    = r_busy;

`ifdef UART_SEQ_DROP_CNT_EN
   logic       w_drop_f, w_drop_m, w_drop_w;
   logic [1:0] w_drops;
   logic [8:0] w_drop_sum;
   logic [7:0] r_drop_cnt;

   // A pulse on a source still pending and not granted this cycle loses the older event.
   assign w_drop_f   = card_flipped & r_pend_f & ~w_gnt_f;
   assign w_drop_m   = card_matched & r_pend_m & ~w_gnt_m;
   assign w_drop_w   = game_won     & r_pend_w & ~w_gnt_w;
   assign w_drops    = {1'b0, w_drop_f} + {1'b0, w_drop_m} + {1'b0, w_drop_w};
   assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drops};

   // saturating drop counter
   always_ff @(posedge clk) begin
      if (reset) r_drop_cnt <= 8'h00;
      else       r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
   end

   assign drop_count = r_drop_cnt;
`endif

endmodule
